// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode codes.
// ST_BREAK exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } uart_state_t;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Parity bit from the XOR-reduction of the data word.
  function automatic logic par_bit_calc(input logic [1:0] mode, input logic data_xor);
    case (mode)
      PAR_EVEN: par_bit_calc = data_xor;
      PAR_ODD:  par_bit_calc = ~data_xor;
      default:  par_bit_calc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with wrap-around pointers, occupancy count and
// registered full/empty flags. Read data is the word at the read pointer.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             push, pop;

  // A write while full is dropped even if a read happens in the same clock.
  assign push = wr_en & ~full_reg;
  assign pop  = rd_en & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign count   = count_reg;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data/parity/stop settings fed from a FIFO.
// Define UART_TX_BREAK_EN to add the tx_break input and BREAK state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 tx_en,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           par_mode,
  input  logic                 stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic                 tx_ovf
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(OVS-1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(DATA_BITS-1);

  uart_state_t          state_reg;
  logic [TW-1:0]        tcnt_reg;
  logic [BW-1:0]        bcnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_en_reg, par_bit_reg, stop2_reg, stop_cnt_reg;
  logic                 txd_reg, busy_reg, ovf_reg;
`ifdef UART_TX_BREAK_EN
  logic                 brk_mark_reg;
`endif

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 bit_end, stop_end, frame_start, break_req;

`ifdef UART_TX_BREAK_EN
  assign break_req = tx_break;
`else
  assign break_req = 1'b0;
`endif

  assign bit_end  = sample_en & (tcnt_reg == TCNT_MAX);
  assign stop_end = (state_reg == ST_STOP) & bit_end & (~stop2_reg | stop_cnt_reg);
  // A pop both starts a frame from IDLE and chains frames straight out of STOP.
  assign frame_start = sample_en & tx_en & (fifo_count != '0) &
                       (((state_reg == ST_IDLE) & ~break_req) | stop_end);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_wr),
    .wr_data (tx_data),
    .rd_en   (frame_start),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tcnt_reg     <= '0;
      bcnt_reg     <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      stop_cnt_reg <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_mark_reg <= 1'b0;
`endif
    end else begin
      ovf_reg <= tx_wr & fifo_full;
      if (sample_en) begin
        tcnt_reg <= bit_end ? '0 : tcnt_reg + 1'b1;
        case (state_reg)
          ST_IDLE: begin
            tcnt_reg <= '0;
`ifdef UART_TX_BREAK_EN
            if (tx_break) begin
              state_reg <= ST_BREAK;
              txd_reg   <= 1'b0;
              busy_reg  <= 1'b1;
            end
`endif
          end
          ST_START: begin
            if (bit_end) begin
              state_reg <= ST_DATA;
              txd_reg   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              if (bcnt_reg == BCNT_MAX) begin
                bcnt_reg  <= '0;
                state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
                txd_reg   <= par_en_reg ? par_bit_reg : 1'b1;
              end else begin
                bcnt_reg  <= bcnt_reg + 1'b1;
                txd_reg   <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
              end
            end
          end
          ST_PARITY: begin
            if (bit_end) begin
              state_reg <= ST_STOP;
              txd_reg   <= 1'b1;
            end
          end
          ST_STOP: begin
            if (bit_end) begin
              if (stop2_reg && !stop_cnt_reg) begin
                stop_cnt_reg <= 1'b1;
              end else begin
                stop_cnt_reg <= 1'b0;
                state_reg    <= ST_IDLE;
                busy_reg     <= 1'b0;
              end
            end
          end
`ifdef UART_TX_BREAK_EN
          // Hold the line low while tx_break is up, then one bit time of mark.
          ST_BREAK: begin
            if (!brk_mark_reg) begin
              tcnt_reg <= '0;
              if (!tx_break) begin
                brk_mark_reg <= 1'b1;
                txd_reg      <= 1'b1;
              end
            end else if (bit_end) begin
              brk_mark_reg <= 1'b0;
              state_reg    <= ST_IDLE;
              busy_reg     <= 1'b0;
            end
          end
`endif
          default: begin
            state_reg <= ST_IDLE;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
          end
        endcase
        // Frame settings are captured here and ignored until the next pop.
        if (frame_start) begin
          state_reg    <= ST_START;
          tcnt_reg     <= '0;
          bcnt_reg     <= '0;
          stop_cnt_reg <= 1'b0;
          shift_reg    <= fifo_rd_data;
          par_en_reg   <= (par_mode != PAR_NONE);
          par_bit_reg  <= par_bit_calc(par_mode, ^fifo_rd_data);
          stop2_reg    <= stop2;
          txd_reg      <= 1'b0;
          busy_reg     <= 1'b1;
        end
      end
    end
  end

  assign txd      = txd_reg;
  assign tx_busy  = busy_reg;
  assign tx_full  = fifo_full;
  assign tx_empty = fifo_empty;
  assign tx_ovf   = ovf_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: records txd/tx_busy once per oversample tick
// and compares bit windows, frame lengths and flags against hand-derived values.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       tx_en;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic [1:0] par_mode;
  logic       stop2;
  logic       tx_break;
  logic       txd, tx_busy, tx_full, tx_empty, tx_ovf;

  int checks = 0;
  int errors = 0;

  logic rec_txd  [1024];
  logic rec_busy [1024];

  uart_tx_cfg #(
    .DATA_BITS  (8),
    .OVS        (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .tx_en     (tx_en),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .par_mode  (par_mode),
    .stop2     (stop2),
`ifdef UART_TX_BREAK_EN
    .tx_break  (tx_break),
`endif
    .txd       (txd),
    .tx_busy   (tx_busy),
    .tx_full   (tx_full),
    .tx_empty  (tx_empty),
    .tx_ovf    (tx_ovf)
  );

  initial forever #5 clk = ~clk;

  // Oversample tick: one clock high out of every two.
  initial begin
    int ph;
    ph = 0;
    sample_en = 1'b0;
    forever begin
      @(negedge clk);
      ph++;
      sample_en = (ph % 2 == 0);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Record txd/tx_busy just after each tick edge; optionally release tx_en or tx_break.
  task automatic capture(input int n, input int drop_en_at, input int drop_brk_at);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 8*n + 16) begin
      @(posedge clk);
      guard++;
      if (sample_en) begin
        #1;
        rec_txd[i]  = txd;
        rec_busy[i] = tx_busy;
        if (i == drop_en_at)  tx_en = 1'b0;
        if (i == drop_brk_at) tx_break = 1'b0;
        i++;
      end
    end
    if (i < n) chk("capture_timeout", i, n);
  endtask

  task automatic write_word(input logic [7:0] d);
    @(negedge clk);
    tx_wr   = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  function automatic int ones(input int from, input int len);
    int c;
    c = 0;
    for (int k = from; k < from + len; k++) c += int'(rec_txd[k]);
    return c;
  endfunction

  function automatic int busy_run(input int limit);
    int c;
    c = 0;
    while (c < limit && rec_busy[c]) c++;
    return c;
  endfunction

  // Sample each data bit at mid-bit; frame starts at tick index base.
  function automatic int decode(input int base);
    int w;
    w = 0;
    for (int b = 0; b < 8; b++) w |= int'(rec_txd[base + 16*(b+1) + 8]) << b;
    return w;
  endfunction

  task automatic check_bits(input string tag, input int base, input int pat[16], input int nb);
    for (int b = 0; b < nb; b++)
      chk($sformatf("%s_bit%0d", tag, b), ones(base + 16*b, 16), pat[b] ? 16 : 0);
  endtask

  initial begin
    int pat1[16] = '{0,1,0,1,0,0,1,0,1,0,1,0,0,0,0,0};
    int pat2[16] = '{0,0,0,0,0,0,0,0,0,1,1,1,0,0,0,0};
    logic [7:0] words[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reset = 1'b1; tx_en = 1'b0; tx_wr = 1'b0; tx_data = '0;
    par_mode = 2'b00; stop2 = 1'b0; tx_break = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd",   int'(txd),      1);
    chk("rst_busy",  int'(tx_busy),  0);
    chk("rst_full",  int'(tx_full),  0);
    chk("rst_empty", int'(tx_empty), 1);
    chk("rst_ovf",   int'(tx_ovf),   0);
    reset = 1'b0;

    // 1: 8E1, 0xA5
    par_mode = 2'b01; stop2 = 1'b0;
    write_word(8'hA5);
    @(negedge clk); tx_en = 1'b1;
    capture(200, -1, -1);
    check_bits("t1", 0, pat1, 11);
    chk("t1_busy_ticks", busy_run(200), 176);
    chk("t1_empty", int'(tx_empty), 1);

    // 2: 8O2, 0x00
    par_mode = 2'b10; stop2 = 1'b1; tx_en = 1'b0;
    write_word(8'h00);
    @(negedge clk); tx_en = 1'b1;
    capture(210, -1, -1);
    check_bits("t2", 0, pat2, 12);
    chk("t2_busy_ticks", busy_run(210), 192);

    // 3: fill FIFO with tx_en low, overflow on the 5th write
    par_mode = 2'b00; stop2 = 1'b0;
    @(negedge clk); tx_en = 1'b0;
    tx_wr = 1'b1; tx_data = words[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3_full_w%0d", i), int'(tx_full), (i >= 3) ? 1 : 0);
      chk($sformatf("t3_ovf_w%0d", i),  int'(tx_ovf),  (i == 4) ? 1 : 0);
      if (i < 4) tx_data = words[i+1];
      else       tx_wr = 1'b0;
    end
    @(negedge clk);
    chk("t3_ovf_clear", int'(tx_ovf), 0);
    tx_en = 1'b1;
    capture(700, -1, -1);
    for (int f = 0; f < 4; f++) begin
      chk($sformatf("t3_start_f%0d", f), ones(160*f, 16), 0);
      chk($sformatf("t3_word_f%0d", f), decode(160*f), int'(words[f]));
    end
    chk("t3_busy_ticks", busy_run(700), 640);
    chk("t3_empty", int'(tx_empty), 1);

    // 4: tx_en dropped mid-DATA
    @(negedge clk); tx_en = 1'b0;
    write_word(8'h3C);
    write_word(8'hC3);
    @(negedge clk); tx_en = 1'b1;
    capture(250, 50, -1);
    chk("t4_word0", decode(0), 8'h3C);
    chk("t4_stop0", ones(144, 16), 16);
    chk("t4_busy0", busy_run(250), 160);
    chk("t4_idle_high", ones(160, 90), 90);
    chk("t4_held", int'(tx_empty), 0);
    @(negedge clk); tx_en = 1'b1;
    capture(200, -1, -1);
    chk("t4_word1", decode(0), 8'hC3);
    chk("t4_busy1", busy_run(200), 160);
    chk("t4_empty", int'(tx_empty), 1);

    // 5: asynchronous reset mid-DATA
    @(negedge clk); tx_en = 1'b0;
    write_word(8'h00);
    write_word(8'h00);
    @(negedge clk); tx_en = 1'b1;
    capture(40, -1, -1);
    @(negedge clk);
    chk("t5_pre_txd", int'(txd), 0);
    #1 reset = 1'b1;
    #1;
    chk("t5_txd",   int'(txd),      1);
    chk("t5_busy",  int'(tx_busy),  0);
    chk("t5_empty", int'(tx_empty), 1);
    @(negedge clk); reset = 1'b0;
    capture(100, -1, -1);
    chk("t5_no_frame", ones(0, 100), 100);
    chk("t5_no_busy", busy_run(100), 0);

`ifdef UART_TX_BREAK_EN
    // 6: break held 40 ticks
    @(negedge clk); tx_break = 1'b1;
    capture(80, -1, 39);
    chk("t6_low",  ones(0, 40), 0);
    chk("t6_mark", ones(40, 16), 16);
    chk("t6_busy", busy_run(80), 56);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
